// File: rtl/alu_result_wb_pkg.sv
// Shared definitions for the ALU result writeback buffer: opcodes, FIFO entry
// layout and a compile-time log2 helper.
package alu_result_wb_pkg;

    localparam logic [3:0] OP_ADD = 4'b0000;
    localparam logic [3:0] OP_SUB = 4'b1000;

    // Entry tag field is sized for the widest tag any instance may use.
    localparam int TAG_MAX_W = 8;

    typedef struct packed {
        logic [62:0]          data;
        logic                 cf;
        logic                 zf;
        logic [TAG_MAX_W-1:0] tag;
    } wb_entry_t;

    function automatic int clog2(input int value);
        int r;
        int v;
        r = 0;
        v = value - 1;
        while (v > 0) begin
            r = r + 1;
            v = v >> 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/alu_wb_flag_gen.sv
// Combinational flag generator: splits a 64-bit add/sub result into value,
// carry/borrow and zero flag; unknown opcodes yield a zeroed value with zf set.
module alu_wb_flag_gen
    import alu_result_wb_pkg::*;
(
    input  logic [3:0]  opcode,
    input  logic [63:0] result,
    output logic [62:0] data,
    output logic        cf,
    output logic        zf
);

    always_comb begin
        data = '0;
        cf   = 1'b0;
        zf   = 1'b1;
        if (opcode == OP_ADD || opcode == OP_SUB) begin
            data = result[62:0];
            cf   = result[63];
            zf   = (result[62:0] == 63'd0);
        end
    end

endmodule

// File: rtl/alu_result_wb.sv
// Writeback FIFO between the add/sub ALU and the register-file write port.
// Optional statistics counters are built when ALU_WB_STATS_EN is defined.
module alu_result_wb
    import alu_result_wb_pkg::*;
#(
    parameter int DEPTH = 4,
    parameter int TAG_W = 3
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [3:0]           in_opcode,
    input  logic [63:0]          in_result,
    input  logic [TAG_W-1:0]     in_tag,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [62:0]          out_data,
    output logic                 out_cf,
    output logic                 out_zf,
    output logic [TAG_W-1:0]     out_tag,
    output logic [clog2(DEPTH):0] out_count
`ifdef ALU_WB_STATS_EN
    ,
    output logic [15:0]          wb_done_cnt,
    output logic [15:0]          full_stall_cnt
`endif
);

    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    wb_entry_t        mem [DEPTH];
    wb_entry_t        new_entry;
    wb_entry_t        head;
    logic [PTR_W-1:0] wptr;
    logic [PTR_W-1:0] rptr;
    logic [CNT_W-1:0] count;
    logic [62:0]      fg_data;
    logic             fg_cf;
    logic             fg_zf;
    logic             push;
    logic             pop;
    logic             tag_unused;

    alu_wb_flag_gen u_flag_gen (
        .opcode (in_opcode),
        .result (in_result),
        .data   (fg_data),
        .cf     (fg_cf),
        .zf     (fg_zf)
    );

    // in_ready depends only on registered occupancy, never on out_ready.
    assign in_ready  = (count != CNT_W'(DEPTH));
    assign out_valid = (count != '0);
    assign push      = in_valid && in_ready;
    assign pop       = out_valid && out_ready;

    always_comb begin
        new_entry      = '0;
        new_entry.data = fg_data;
        new_entry.cf   = fg_cf;
        new_entry.zf   = fg_zf;
        new_entry.tag  = TAG_MAX_W'(in_tag);
    end

    // Storage is cleared on reset so the head reads as all-zero afterwards.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem[i] <= '0;
            end
        end else if (push) begin
            mem[wptr] <= new_entry;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wptr  <= '0;
            rptr  <= '0;
            count <= '0;
        end else begin
            if (push) begin
                wptr <= wptr + 1'b1;
            end
            if (pop) begin
                rptr <= rptr + 1'b1;
            end
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    assign head       = mem[rptr];
    assign out_data   = head.data;
    assign out_cf     = head.cf;
    assign out_zf     = head.zf;
    assign out_tag    = head.tag[TAG_W-1:0];
    assign out_count  = count;
    assign tag_unused = ^head.tag;

`ifdef ALU_WB_STATS_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_done_cnt    <= '0;
            full_stall_cnt <= '0;
        end else begin
            if (pop) begin
                wb_done_cnt <= wb_done_cnt + 1'b1;
            end
            if (in_valid && !in_ready && full_stall_cnt != 16'hFFFF) begin
                full_stall_cnt <= full_stall_cnt + 1'b1;
            end
        end
    end
`endif

endmodule
